// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the PWM ramp controller.
package pwm_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned DEF_DUTY_W  = 9;
    localparam int unsigned DEF_PERIOD  = 500;
    localparam int unsigned DEF_CLK_DIV = 10;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and emits a one-clk tick on the last count.
// While clear is high the prescaler is held at 0 and no tick is produced.
module pwm_tick_gen #(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;

    // Next prescaler value and tick decode.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// Single-channel PWM sequencer: prescaler, period counter, valid/ready duty
// target intake and per-period ramping of the applied duty.
// Optional complementary output with dead time: define PWM_COMPLEMENT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | enable low; counters held at 0, output off, targets accepted
// RAMP  | dutyNow stepping toward target once per period; no intake
// HOLD  | dutyNow == target; new targets accepted
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned PERIOD     = DEF_PERIOD,
    parameter int unsigned DUTY_W     = DEF_DUTY_W
`ifdef PWM_COMPLEMENT_EN
    ,
    parameter int unsigned DEAD_TICKS = 2
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cfgValid,
    output logic              cfgReady,
    input  logic [DUTY_W-1:0] cfgDuty,
    input  logic [DUTY_W-1:0] cfgStep,
    output logic              pwmOut,
    output logic [DUTY_W-1:0] dutyNow,
    output logic              rampBusy,
    output logic              periodStart
`ifdef PWM_COMPLEMENT_EN
    ,
    output logic              pwmOutN
`endif
);

    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PERIOD - 1);
    localparam logic [DUTY_W:0]   PERIOD_X = (DUTY_W + 1)'(PERIOD);

    state_t            state_q, state_d;
    logic [DUTY_W-1:0] count_q, count_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W-1:0] step_q, step_d;
    logic              pwm_q, pwm_d;
    logic              ps_q, ps_d;

    logic              tick;
    logic              run;
    logic              wrap;
    logic              xfer;
    logic [DUTY_W:0]   duty_x, target_x, step_x, count_x;
    logic [DUTY_W:0]   cfg_clamped;
    logic [DUTY_W:0]   ramp_next;

    assign run      = enable && (state_q != IDLE);
    assign wrap     = run && tick && (count_q == CNT_LAST);
    assign cfgReady = (state_q != RAMP);
    assign xfer     = cfgValid && cfgReady;

    assign duty_x   = {1'b0, duty_q};
    assign target_x = {1'b0, target_q};
    assign step_x   = {1'b0, step_q};
    assign count_x  = {1'b0, count_q};

    pwm_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!run),
        .tick    (tick)
    );

    // Clamp the offered target to a full period.
    always_comb begin
        cfg_clamped = {1'b0, cfgDuty};
        if (cfg_clamped > PERIOD_X) cfg_clamped = PERIOD_X;
    end

    // One ramp step toward target, never overshooting; step 0 jumps.
    always_comb begin
        ramp_next = target_x;
        if (step_x != '0) begin
            if (duty_x < target_x) begin
                if ((duty_x + step_x) < target_x) ramp_next = duty_x + step_x;
            end else if (duty_x > (target_x + step_x)) begin
                ramp_next = duty_x - step_x;
            end
        end
    end

    // Period counter, period-start pulse and PWM compare.
    always_comb begin
        count_d = count_q;
        if (!run)           count_d = '0;
        else if (tick)      count_d = (count_q == CNT_LAST) ? '0 : count_q + 1'b1;
        ps_d  = wrap;
        pwm_d = run && (count_x < duty_x);
    end

    // Sequencing FSM and target/step/duty registers' next values.
    // The duty update is applied on the wrap edge so the new value is in
    // place for the whole first tick of the new period.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        step_d   = step_q;
        duty_d   = duty_q;
        if (xfer) begin
            target_d = cfg_clamped[DUTY_W-1:0];
            step_d   = cfgStep;
        end
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = (target_d != duty_q) ? RAMP : HOLD;
                RAMP: begin
                    if (wrap) begin
                        duty_d = ramp_next[DUTY_W-1:0];
                        if (ramp_next == target_x) state_d = HOLD;
                    end
                end
                HOLD: if (xfer && (target_d != duty_q)) state_d = RAMP;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
        end
    end

    assign pwmOut      = pwm_q;
    assign dutyNow     = duty_q;
    assign periodStart = ps_q;
    assign rampBusy    = enable && (duty_q != target_q);

`ifdef PWM_COMPLEMENT_EN
    localparam logic [DUTY_W:0] DEAD_X = (DUTY_W + 1)'(DEAD_TICKS);

    logic pwmn_q, pwmn_d;

    // Complementary output: low for DEAD_TICKS around both edges of pwmOut.
    always_comb begin
        pwmn_d = run && (count_x >= (duty_x + DEAD_X)) && (count_x < (PERIOD_X - DEAD_X));
    end

    // Complementary output register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pwmn_q <= 1'b0;
        else          pwmn_q <= pwmn_d;
    end

    assign pwmOutN = pwmn_q;
`endif

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Self-checking bench for pwm_ramp_controller (CLK_DIV=2, PERIOD=10).
// Also covers the complementary output when PWM_COMPLEMENT_EN is defined.
module tb_pwm_ramp_controller;

    localparam int CLK_DIV = 2;
    localparam int PERIOD  = 10;
    localparam int DUTY_W  = 5;
    localparam int DEAD    = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              cfgValid = 1'b0;
    logic [DUTY_W-1:0] cfgDuty = '0;
    logic [DUTY_W-1:0] cfgStep = '0;
    logic              cfgReady;
    logic              pwmOut;
    logic [DUTY_W-1:0] dutyNow;
    logic              rampBusy;
    logic              periodStart;
`ifdef PWM_COMPLEMENT_EN
    logic              pwmOutN;
`endif

    always #5 clk = ~clk;

    pwm_ramp_controller #(
        .CLK_DIV     (CLK_DIV),
        .PERIOD      (PERIOD),
        .DUTY_W      (DUTY_W)
`ifdef PWM_COMPLEMENT_EN
        ,
        .DEAD_TICKS  (DEAD)
`endif
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfgValid    (cfgValid),
        .cfgReady    (cfgReady),
        .cfgDuty     (cfgDuty),
        .cfgStep     (cfgStep),
        .pwmOut      (pwmOut),
        .dutyNow     (dutyNow),
        .rampBusy    (rampBusy),
        .periodStart (periodStart)
`ifdef PWM_COMPLEMENT_EN
        ,
        .pwmOutN     (pwmOutN)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since the channel started running plus the
    // duty/target/step values; counter position is derived arithmetically.
    bit m_run, m_ramp, m_pwm, m_pwmn, m_ps;
    int m_clks, m_duty, m_target, m_step;
    int ps_log[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int approach(input int d, input int t, input int s);
        if (s == 0)     return t;
        if (d < t)      return (d + s > t) ? t : d + s;
        return (d - s < t) ? t : d - s;
    endfunction

    task automatic model_reset();
        m_run = 0; m_ramp = 0; m_pwm = 0; m_pwmn = 0; m_ps = 0;
        m_clks = 0; m_duty = 0; m_target = 0; m_step = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input int d, input int s);
        int  cnt;
        bit  ready, xfer, old_ramp;
        int  nt;
        cnt      = (m_clks / CLK_DIV) % PERIOD;
        ready    = !(m_run && m_ramp);
        xfer     = v && ready;
        nt       = xfer ? ((d > PERIOD) ? PERIOD : d) : m_target;
        old_ramp = m_ramp;
        m_pwm    = en && m_run && (cnt < m_duty);
        m_pwmn   = en && m_run && (cnt >= m_duty + DEAD) && (cnt < PERIOD - DEAD);
        m_ps     = 0;
        if (!en) begin
            m_run  = 0;
            m_clks = 0;
        end else if (!m_run) begin
            m_run  = 1;
            m_clks = 0;
            m_ramp = (nt != m_duty);
        end else begin
            m_clks++;
            if (m_clks % (CLK_DIV * PERIOD) == 0) begin
                m_ps = 1;
                if (old_ramp) begin
                    m_duty = approach(m_duty, m_target, m_step);
                    if (m_duty == m_target) m_ramp = 0;
                end
            end
            if (!old_ramp && xfer && nt != m_duty) m_ramp = 1;
        end
        m_target = nt;
        if (xfer) m_step = s;
    endtask

    // Drive one clock of inputs, advance the model, compare at the falling edge.
    task automatic cycle(input bit en, input bit v, input int d, input int s);
        enable   = en;
        cfgValid = v;
        cfgDuty  = DUTY_W'(d);
        cfgStep  = DUTY_W'(s);
        @(posedge clk);
        model_edge(en, v, d, s);
        @(negedge clk);
        check_val("pwmOut", pwmOut, m_pwm);
        check_val("dutyNow", dutyNow, m_duty);
        check_val("periodStart", periodStart, m_ps);
        check_val("cfgReady", cfgReady, !(m_run && m_ramp));
        check_val("rampBusy", rampBusy, en && (m_duty != m_target));
`ifdef PWM_COMPLEMENT_EN
        check_val("pwmOutN", pwmOutN, m_pwmn);
        check_val("no_overlap", pwmOut && pwmOutN, 1'b0);
`endif
        if (periodStart === 1'b1) ps_log.push_back(int'(dutyNow));
    endtask

    task automatic idle_run(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
    endtask

    task automatic wait_duty(input int want, input int budget);
        int k;
        k = 0;
        while (int'(dutyNow) != want && k < budget) begin
            cycle(1, 0, 0, 0);
            k++;
        end
        check_val("wait_duty", dutyNow, want);
    endtask

    initial begin
        int highs;
        int spins;
        model_reset();
        repeat (2) @(negedge clk);
        check_val("rst_pwmOut", pwmOut, 0);
        check_val("rst_dutyNow", dutyNow, 0);
        check_val("rst_periodStart", periodStart, 0);
        check_val("rst_rampBusy", rampBusy, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_cfgReady", cfgReady, 1);

        // Jump to duty 4 with step 0, then hold.
        cycle(1, 1, 4, 0);
        check_val("jump_ready_drop", cfgReady, 0);
        ps_log.delete();
        idle_run(45);
        check_val("jump_first_ps", (ps_log.size() > 0) ? ps_log[0] : -1, 4);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            if (pwmOut === 1'b1) highs++;
        end
        check_val("duty4_high_clks", highs, 8);

        // Asynchronous reset mid-period while the output is high.
        spins = 0;
        while (pwmOut !== 1'b1 && spins < 40) begin
            cycle(1, 0, 0, 0);
            spins++;
        end
        check_val("pre_reset_high", pwmOut, 1);
        #2 reset_n = 1'b0;
        enable = 1'b0; cfgValid = 1'b0;
        #1;
        check_val("async_pwmOut", pwmOut, 0);
        check_val("async_dutyNow", dutyNow, 0);
        check_val("async_periodStart", periodStart, 0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1 check_val("release_cfgReady", cfgReady, 1);

        // Back to duty 4, then ramp to 9 with step 2.
        cycle(1, 1, 4, 0);
        idle_run(45);
        cycle(1, 1, 9, 2);
        ps_log.delete();
        idle_run(70);
        check_val("ramp_ps0", (ps_log.size() > 0) ? ps_log[0] : -1, 6);
        check_val("ramp_ps1", (ps_log.size() > 1) ? ps_log[1] : -1, 8);
        check_val("ramp_ps2", (ps_log.size() > 2) ? ps_log[2] : -1, 9);
        check_val("ramp_done_busy", rampBusy, 0);
        check_val("ramp_done_ready", cfgReady, 1);

        // Clamp to a full period, then fall to zero.
        cycle(1, 1, 15, 0);
        idle_run(45);
        check_val("clamp_duty", dutyNow, PERIOD);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            if (pwmOut === 1'b1) highs++;
        end
        check_val("full_high_clks", highs, 20);
        cycle(1, 1, 0, 0);
        idle_run(45);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            if (pwmOut === 1'b1) highs++;
        end
        check_val("zero_high_clks", highs, 0);

        // Drop enable mid-ramp at duty 6 and resume.
        cycle(1, 1, 4, 0);
        idle_run(45);
        cycle(1, 1, 9, 2);
        wait_duty(6, 100);
        cycle(0, 0, 0, 0);
        check_val("drop_pwmOut", pwmOut, 0);
        check_val("drop_periodStart", periodStart, 0);
        idle_run(0);
        ps_log.delete();
        idle_run(50);
        check_val("resume_ps0", (ps_log.size() > 0) ? ps_log[0] : -1, 8);
        check_val("resume_ps1", (ps_log.size() > 1) ? ps_log[1] : -1, 9);

`ifdef PWM_COMPLEMENT_EN
        // Complement window for duty 4: ticks 6 and 7 only (4 clks).
        cycle(1, 1, 4, 0);
        idle_run(45);
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 0, 0, 0);
            if (pwmOutN === 1'b1) highs++;
        end
        check_val("compl_high_clks", highs, 4);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            cycle(($urandom_range(0, 99) < 95),
                  ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
